// File: rtl/hls_saturation_mul_pkg.sv
// Shared constants and helpers for the time-shared saturation-enhance multiplier.
// Holds default operand widths, ID width derivation and the round-robin successor function.
package hls_saturation_mul_pkg;

  localparam int unsigned A_WIDTH_DEF = 20;
  localparam int unsigned B_WIDTH_DEF = 8;
  localparam int unsigned P_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A single requester still needs a one-bit ID field.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Wraps modulo the requester count, not modulo 2^ID_W.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hls_saturation_mul_pipe.sv
// Unsigned A x B multiplier with MUL_STAGES output registers, data only.
// No reset on the data path so the registers can be absorbed into a DSP block.
module hls_saturation_mul_pipe
  import hls_saturation_mul_pkg::*;
#(
  parameter int unsigned A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH    = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH    = P_WIDTH_DEF,
  parameter int unsigned MUL_STAGES = 3
) (
  input  logic               clk_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic [P_WIDTH-1:0] p_o
);

  logic [P_WIDTH-1:0] p_d [MUL_STAGES];
  logic [P_WIDTH-1:0] p_q [MUL_STAGES];

  always_comb begin
    p_d[0] = P_WIDTH'(a_i) * P_WIDTH'(b_i);
    for (int unsigned i = 1; i < MUL_STAGES; i++) begin
      p_d[i] = p_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    p_q <= p_d;
  end

  assign p_o = p_q[MUL_STAGES-1];

endmodule

// File: rtl/hls_saturation_mul_sched.sv
// Round-robin scheduler sharing one pipelined unsigned multiplier among NUM_REQ requesters.
// Results return in acceptance order on a shared bus tagged with the requester index.
module hls_saturation_mul_sched
  import hls_saturation_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH    = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH    = P_WIDTH_DEF,
  parameter int unsigned MUL_STAGES = 3,
  localparam int unsigned ID_W      = id_width(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       cfg_enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       busy,
  output logic [31:0]                op_count
);

  // Tag stage 0 sits beside the operand registers; stages 1..MUL_STAGES track the multiplier.
  localparam int unsigned TagStages = MUL_STAGES + 1;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [A_WIDTH-1:0] grant_a;
  logic [B_WIDTH-1:0] grant_b;
  logic               accept;

  logic [ID_W-1:0]    ptr_d, ptr_q;
  logic [31:0]        op_count_d, op_count_q;
  logic [A_WIDTH-1:0] a_d, a_q;
  logic [B_WIDTH-1:0] b_d, b_q;
  logic [TagStages-1:0] vld_d, vld_q;
  logic [ID_W-1:0]    id_d [TagStages];
  logic [ID_W-1:0]    id_q [TagStages];
  logic               rsp_valid_d, rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_d, rsp_id_q;
  logic [P_WIDTH-1:0] rsp_p_d, rsp_p_q;
  logic [P_WIDTH-1:0] mul_p;

  always_comb begin : arb
    int unsigned idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 32'(ptr_q);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = rr_next(idx, NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Ready is gated by reset too, so nothing can be accepted while the pipeline is held clear.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && cfg_enable && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept = |(req_ready & req_valid);

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_a = req_a[i*A_WIDTH +: A_WIDTH];
        grant_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d      = accept ? grant_id : ptr_q;
    op_count_d = op_count_q + (accept ? 32'd1 : 32'd0);
    a_d        = accept ? grant_a : a_q;
    b_d        = accept ? grant_b : b_q;
    vld_d[0]   = accept;
    id_d[0]    = grant_id;
    for (int unsigned i = 1; i < TagStages; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
    rsp_valid_d = vld_q[MUL_STAGES];
    rsp_id_d    = vld_q[MUL_STAGES] ? id_q[MUL_STAGES] : rsp_id_q;
    rsp_p_d     = vld_q[MUL_STAGES] ? mul_p : rsp_p_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      op_count_q  <= '0;
      vld_q       <= '0;
      id_q        <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      op_count_q  <= op_count_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  hls_saturation_mul_pipe #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .P_WIDTH    (P_WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk_i (ap_clk),
    .a_i   (a_q),
    .b_i   (b_q),
    .p_o   (mul_p)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (|vld_q) | rsp_valid_q;
  assign op_count  = op_count_q;

endmodule
